// File: rtl/pkt_recv_checker.sv
// pkt_recv_checker
// Receive-side checker for one switch output port. It parses each packet
// header, checks that payload beat k carries the value k, and reports
// per-packet status plus saturating packet and error totals.
module pkt_recv_checker #(
    parameter int PORT_NUB_TOTAL  = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_LENGTH_MAX = 64,
    parameter int PRIORITY        = 4,
    parameter int PORT_ID         = 0,
    parameter int WIDTH_SEL       = $clog2(PORT_NUB_TOTAL),
    parameter int WIDTH_PRIORITY  = $clog2(PRIORITY),
    parameter int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      rd_sop,
    input  logic                      rd_eop,
    input  logic                      rd_vld,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      ready,
    output logic                      pkt_done,
    output logic [WIDTH_PRIORITY-1:0] pkt_priority,
    output logic [WIDTH_LENGTH-1:0]   pkt_length,
    output logic                      err_dest,
    output logic                      err_length,
    output logic                      err_data,
    output logic                      err_frame,
    output logic [15:0]               pkt_cnt,
    output logic [15:0]               err_cnt
);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    // Everything reported about one finished packet.
    typedef struct packed {
        logic [WIDTH_PRIORITY-1:0] prio;
        logic [WIDTH_LENGTH-1:0]   len;
        logic                      errDest;
        logic                      errLength;
        logic                      errData;
        logic                      errFrame;
    } result_t;

    localparam logic [WIDTH_SEL-1:0]    DEST_ID = WIDTH_SEL'(PORT_ID);
    localparam logic [WIDTH_LENGTH-1:0] CNT_MAX = '1;

    state_t                    r_state;
    logic [WIDTH_SEL-1:0]      r_dest;
    logic [WIDTH_PRIORITY-1:0] r_prio;
    logic [WIDTH_LENGTH-1:0]   r_len;
    logic [WIDTH_LENGTH-1:0]   r_cnt;
    logic                      r_errData;
    logic                      r_errLength;
    logic                      r_pendValid;
    result_t                   r_pend;

    logic [WIDTH_SEL-1:0]      w_hdrDest;
    logic [WIDTH_PRIORITY-1:0] w_hdrPrio;
    logic [WIDTH_LENGTH-1:0]   w_hdrLen;
    logic [WIDTH_LENGTH-1:0]   w_cntNext;
    logic                      w_mismatch;
    logic                      w_over;
    result_t                   w_hdrResult;
    result_t                   w_prim;
    logic                      w_primValid;
    result_t                   w_sec;
    logic                      w_secValid;
    result_t                   w_emit;
    logic                      w_emitValid;
    logic                      w_anyErr;

    // Header fields are packed upward from bit 0: dest, priority, length.
    assign w_hdrDest  = rd_data[WIDTH_SEL-1:0];
    assign w_hdrPrio  = rd_data[WIDTH_SEL +: WIDTH_PRIORITY];
    assign w_hdrLen   = rd_data[WIDTH_SEL+WIDTH_PRIORITY +: WIDTH_LENGTH];
    assign w_cntNext  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_mismatch = (rd_data != DATA_WIDTH'(r_cnt));
    assign w_over     = (r_cnt >= r_len);

    // Work out which packet(s) finish on this beat. A sop+eop beat that
    // aborts an open packet finishes two packets at once; the second one
    // (always header-only) is parked in the pending slot for one cycle.
    // The pending slot is only ever occupied while in IDLE, where a beat
    // can finish at most one packet, so one slot is enough.
    always_comb begin
        w_hdrResult           = '0;
        w_hdrResult.prio      = w_hdrPrio;
        w_hdrResult.errDest   = (w_hdrDest != DEST_ID);
        w_hdrResult.errLength = (w_hdrLen != '0);
        w_prim                = '0;
        w_primValid           = 1'b0;
        w_sec                 = '0;
        w_secValid            = 1'b0;
        if (rd_vld) begin
            case (r_state)
                IDLE: begin
                    if (rd_sop && rd_eop) begin
                        w_primValid = 1'b1;
                        w_prim      = w_hdrResult;
                    end
                end
                PAYLOAD: begin
                    if (rd_sop) begin
                        w_primValid        = 1'b1;
                        w_prim.prio        = r_prio;
                        w_prim.len         = r_cnt;
                        w_prim.errDest     = (r_dest != DEST_ID);
                        w_prim.errLength   = r_errLength | (r_cnt != r_len);
                        w_prim.errData     = r_errData;
                        w_prim.errFrame    = 1'b1;
                        w_secValid         = rd_eop;
                        w_sec              = w_hdrResult;
                    end else if (rd_eop) begin
                        w_primValid        = 1'b1;
                        w_prim.prio        = r_prio;
                        w_prim.len         = w_cntNext;
                        w_prim.errDest     = (r_dest != DEST_ID);
                        w_prim.errLength   = r_errLength | w_over | (w_cntNext != r_len);
                        w_prim.errData     = r_errData | w_mismatch;
                    end
                end
                default: ;
            endcase
        end
        w_emitValid = r_pendValid | w_primValid;
        w_emit      = r_pendValid ? r_pend : w_prim;
        w_anyErr    = w_emit.errDest | w_emit.errLength | w_emit.errData | w_emit.errFrame;
    end

    // Packet parser state machine with registered completion outputs and totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dest       <= '0;
            r_prio       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_errData    <= 1'b0;
            r_errLength  <= 1'b0;
            r_pendValid  <= 1'b0;
            r_pend       <= '0;
            pkt_done     <= 1'b0;
            pkt_priority <= '0;
            pkt_length   <= '0;
            err_dest     <= 1'b0;
            err_length   <= 1'b0;
            err_data     <= 1'b0;
            err_frame    <= 1'b0;
            pkt_cnt      <= '0;
            err_cnt      <= '0;
        end else begin
            pkt_done <= w_emitValid;
            if (w_emitValid) begin
                pkt_priority <= w_emit.prio;
                pkt_length   <= w_emit.len;
                err_dest     <= w_emit.errDest;
                err_length   <= w_emit.errLength;
                err_data     <= w_emit.errData;
                err_frame    <= w_emit.errFrame;
                if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
                if (w_anyErr && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            if (r_pendValid) begin
                r_pendValid <= w_primValid;
                r_pend      <= w_prim;
            end else begin
                r_pendValid <= w_secValid;
                r_pend      <= w_sec;
            end
            if (rd_vld) begin
                if (rd_sop) begin
                    r_dest      <= w_hdrDest;
                    r_prio      <= w_hdrPrio;
                    r_len       <= w_hdrLen;
                    r_cnt       <= '0;
                    r_errData   <= 1'b0;
                    r_errLength <= 1'b0;
                    r_state     <= rd_eop ? IDLE : PAYLOAD;
                end else if (r_state == PAYLOAD) begin
                    r_cnt       <= w_cntNext;
                    r_errData   <= r_errData | w_mismatch;
                    r_errLength <= r_errLength | w_over;
                    if (rd_eop) r_state <= IDLE;
                end
            end
        end
    end

    // Ready simply advertises the enable one cycle later; reception ignores it.
    always_ff @(posedge clk) begin
        if (rst) ready <= 1'b0;
        else     ready <= en;
    end

endmodule
